// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan sequencer:
//   - SEL_W         : width of the select code driven to the 3-to-8 decoder
//   - scan_state_e  : FSM state encoding (ST_IDLE / ST_RUN)
//   - idx_min/max   : first and last legal select index for a given NUM_SEL
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  // Lowest select index ever emitted.
  function automatic logic [SEL_W-1:0] idx_min();
    return '0;
  endfunction

  // Highest select index ever emitted; the index wraps here.
  function automatic logic [SEL_W-1:0] idx_max(input int num_sel);
    return SEL_W'(num_sel - 1);
  endfunction

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// DWELL_W-bit down-counter that measures how long one select is held.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (takes priority over counting)
//   i_load_val   : reload value, always >= 1 when used by the sequencer
//   i_en         : count down while high
//   o_expire     : high during the last cycle of the current dwell
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_expire
);

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // A count of 1 means the present cycle is the last one of the dwell;
  // the owner reloads on this cycle so the next select gets a full dwell.
  assign o_expire = i_en && (r_cnt == CNT_ONE);

endmodule

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Generates the 3-bit select code for a 3-to-8 decoder, stepping through
// selects 0..NUM_SEL-1 up or down, holding each for a programmable dwell,
// either continuously or as a single pass.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a scan (sampled only in IDLE, stop wins)
//   stop                 : abort the running scan
//   dir, oneshot, dwell  : direction / single-pass / dwell, latched at start
//   sel_a, sel_b, sel_c  : select code, a = MSB, c = LSB
//   valid, busy          : select live / FSM in RUN
//   wrap                 : one-cycle pulse when a continuous scan re-enters
//                          its start index
//   done                 : one-cycle pulse on the first IDLE cycle after a
//                          oneshot pass completes
//   dbg_state            : current FSM state for observation
// Handshake: none; start is a level request acted on in IDLE, all outputs
// are registered so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int NUM_SEL = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic               valid,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output scan_state_e        dbg_state
);

  localparam logic [SEL_W-1:0]   IDX_MIN  = idx_min();
  localparam logic [SEL_W-1:0]   IDX_MAX  = idx_max(NUM_SEL);
  localparam logic [SEL_W-1:0]   IDX_ONE  = SEL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  scan_state_e        r_state;
  logic [SEL_W-1:0]   r_idx;
  logic               r_dir_l;
  logic               r_oneshot_l;
  logic [DWELL_W-1:0] r_dwell_l;
  logic               r_valid;
  logic               r_busy;
  logic               r_wrap;
  logic               r_done;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic               w_accept;
  logic               w_advance;
  logic               w_expire;
  logic               w_load;
  logic [DWELL_W-1:0] w_load_val;
  logic [SEL_W-1:0]   w_idx_next;
  logic [SEL_W-1:0]   w_idx_start;
  logic [SEL_W-1:0]   w_idx_end;

  // A dwell of 0 would never expire; treat it as a single cycle.
  assign w_dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

  assign w_accept  = (r_state == ST_IDLE) && start && !stop;
  assign w_advance = (r_state == ST_RUN) && !stop && w_expire;

  // The timer is loaded with the fresh dwell on start and reloaded with the
  // latched dwell on every advance, so each index gets exactly dwell_l cycles.
  assign w_load     = w_accept || w_advance;
  assign w_load_val = (r_state == ST_IDLE) ? w_dwell_eff : r_dwell_l;

  // Start and end indices depend on the latched direction.
  assign w_idx_start = r_dir_l ? IDX_MAX : IDX_MIN;
  assign w_idx_end   = r_dir_l ? IDX_MIN : IDX_MAX;

  always_comb begin
    w_idx_next = r_idx;
    if (r_dir_l) begin
      w_idx_next = (r_idx == IDX_MIN) ? IDX_MAX : (r_idx - IDX_ONE);
    end else begin
      w_idx_next = (r_idx == IDX_MAX) ? IDX_MIN : (r_idx + IDX_ONE);
    end
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (r_state == ST_RUN),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= IDX_MIN;
      r_dir_l     <= 1'b0;
      r_oneshot_l <= 1'b0;
      r_dwell_l   <= DWELL_ONE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // wrap and done are single-cycle pulses unless re-armed below.
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RUN;
            r_dir_l     <= dir;
            r_oneshot_l <= oneshot;
            r_dwell_l   <= w_dwell_eff;
            r_idx       <= dir ? IDX_MAX : IDX_MIN;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort: sel freezes on the index that was showing.
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_expire) begin
            if (r_oneshot_l && (r_idx == w_idx_end)) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
              // Only a later return to the start index counts as a wrap;
              // the initial entry is set on the IDLE->RUN edge instead.
              if (!r_oneshot_l && (w_idx_next == w_idx_start)) begin
                r_wrap <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_a     = r_idx[2];
  assign sel_b     = r_idx[1];
  assign sel_c     = r_idx[0];
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign wrap      = r_wrap;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;
  import scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       start5;
  logic       stop;
  logic       dir;
  logic       oneshot;
  logic [7:0] dwell;

  logic sel_a8, sel_b8, sel_c8, valid8, busy8, wrap8, done8;
  logic sel_a5, sel_b5, sel_c5, valid5, busy5, wrap5, done5;
  scan_state_e dbg8, dbg5;

  scan_sequencer #(.DWELL_W(8), .NUM_SEL(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .oneshot(oneshot), .dwell(dwell),
    .sel_a(sel_a8), .sel_b(sel_b8), .sel_c(sel_c8), .valid(valid8),
    .busy(busy8), .wrap(wrap8), .done(done8), .dbg_state(dbg8)
  );

  scan_sequencer #(.DWELL_W(8), .NUM_SEL(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .stop(stop), .dir(dir),
    .oneshot(oneshot), .dwell(dwell),
    .sel_a(sel_a5), .sel_b(sel_b5), .sel_c(sel_c5), .valid(valid5),
    .busy(busy5), .wrap(wrap5), .done(done5), .dbg_state(dbg5)
  );

  // ---------------- scoreboard ----------------
  // Entry: bit 7 selects the DUT (0 = NUM_SEL 8, 1 = NUM_SEL 5),
  // bits 6:0 = {sel[2:0], valid, busy, wrap, done}.
  logic [7:0] exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  string tag    = "init";

  function automatic logic [7:0] pk(input bit dut5, input int sel, input bit v,
                                    input bit b, input bit w, input bit d);
    logic [2:0] s;
    s = 3'(sel);
    return {dut5, s, v, b, w, d};
  endfunction

  task automatic check();
    logic [7:0] e;
    logic [6:0] obs;
    e = exp_q.pop_front();
    if (e[7]) obs = {sel_a5, sel_b5, sel_c5, valid5, busy5, wrap5, done5};
    else      obs = {sel_a8, sel_b8, sel_c8, valid8, busy8, wrap8, done8};
    n_cmp++;
    assert (obs === e[6:0]) else begin
      n_fail++;
      $error("FAIL %s: observed {sel,v,b,w,d}=%b expected %b", tag, obs, e[6:0]);
    end
  endtask

  // Driver: inputs already set apply at the next rising edge; the expected
  // post-edge outputs are queued, then sampled at the falling edge.
  task automatic tick(input logic [7:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b1; start5 = 1'b0; stop = 1'b0;
    dir = 1'b0; oneshot = 1'b0; dwell = 8'd3;

    // 1: reset held with start high, then idle after release
    tag = "reset";
    tick(pk(0, 0, 0, 0, 0, 0));
    tick(pk(0, 0, 0, 0, 0, 0));
    rst = 1'b0; start = 1'b0;
    tag = "post_reset_idle";
    tick(pk(0, 0, 0, 0, 0, 0));
    tick(pk(0, 0, 0, 0, 0, 0));
    tick(pk(1, 0, 0, 0, 0, 0));

    // 2: oneshot up, dwell 3
    tag = "oneshot_up_d3";
    dir = 1'b0; oneshot = 1'b1; dwell = 8'd3; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        tick(pk(0, i, 1, 1, 0, 0));
        start = 1'b0;
      end
    end
    tag = "oneshot_up_done";
    tick(pk(0, 7, 0, 0, 0, 1));
    tag = "oneshot_up_after";
    tick(pk(0, 7, 0, 0, 0, 0));

    // 3: continuous down, dwell 1, wrap on each return to 7
    tag = "cont_down_d1";
    dir = 1'b1; oneshot = 1'b0; dwell = 8'd1; start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick(pk(0, 7 - ((c - 1) % 8), 1, 1, (c > 1) && ((c - 1) % 8 == 0), 0));
      start = 1'b0;
    end
    tag = "cont_down_stop";
    stop = 1'b1;
    tick(pk(0, 0, 0, 0, 0, 0));
    stop = 1'b0;

    // 4: NUM_SEL 5, dwell 0 behaves as dwell 1
    tag = "ns5_dwell0";
    dir = 1'b0; oneshot = 1'b1; dwell = 8'd0; start5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(pk(1, i, 1, 1, 0, 0));
      start5 = 1'b0;
    end
    tag = "ns5_done";
    tick(pk(1, 4, 0, 0, 0, 1));
    tag = "ns5_after";
    tick(pk(1, 4, 0, 0, 0, 0));

    // 5: continuous up, dwell 4, stop during sel 3
    tag = "cont_up_d4";
    dir = 1'b0; oneshot = 1'b0; dwell = 8'd4; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        tick(pk(0, i, 1, 1, 0, 0));
        start = 1'b0;
      end
    end
    tick(pk(0, 3, 1, 1, 0, 0));
    tick(pk(0, 3, 1, 1, 0, 0));
    tag = "stop_mid_dwell";
    stop = 1'b1;
    tick(pk(0, 3, 0, 0, 0, 0));
    tag = "start_and_stop_idle";
    start = 1'b1;
    tick(pk(0, 3, 0, 0, 0, 0));
    start = 1'b0; stop = 1'b0;
    tick(pk(0, 3, 0, 0, 0, 0));

    // 6: continuous up, dwell 2; start with new settings mid-run is ignored;
    //    wrap on re-entry to 0; reset mid-scan at sel 5
    tag = "cont_up_d2_ignore_start";
    dir = 1'b0; oneshot = 1'b0; dwell = 8'd2; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i == 2) begin
          start = 1'b1; dwell = 8'd5; dir = 1'b1; oneshot = 1'b1;
        end else if (!(i == 0 && k == 0)) begin
          start = 1'b0;
        end
        tick(pk(0, i, 1, 1, 0, 0));
      end
    end
    start = 1'b0;
    tag = "cont_up_wrap";
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        tick(pk(0, i, 1, 1, (i == 0) && (k == 0), 0));
      end
    end
    tick(pk(0, 5, 1, 1, 0, 0));
    tag = "reset_mid_scan";
    rst = 1'b1;
    tick(pk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tag = "idle_after_reset";
    tick(pk(0, 0, 0, 0, 0, 0));
    tick(pk(0, 0, 0, 0, 0, 0));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
